// File: rtl/id_hazard_scheduler_pkg.sv
// Shared types and constants for the ID-stage hazard scheduler.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package id_hazard_scheduler_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 1 << REG_IDX_W;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      BWAIT = 2'd1,
      FLUSH = 2'd2
   } sched_state_e;

   // One in-flight destination between ID issue and register-file write.
   typedef struct packed {
      logic                 vld;
      logic [REG_IDX_W-1:0] rd;
   } inflight_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] r);
      logic [NUM_REGS-1:0] oh;
      oh    = '0;
      oh[r] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/id_hazard_scheduler_if.sv
// ID-stage issue/branch bundle between the fetch/ID registers and the scheduler.
// Latency: wires only.
// Backpressure: id_ready from the scheduler throttles the ID stage.
// Ports: ID instruction fields and control bits, EX branch outcome (master -> slave);
//        id_ready, issue, flush, busy_mask, stall_cnt (slave -> master).
interface id_hazard_scheduler_if #(parameter int CNT_W = 16);
   import id_hazard_scheduler_pkg::*;

   logic                 id_valid;
   logic [REG_IDX_W-1:0] id_rs1;
   logic [REG_IDX_W-1:0] id_rs2;
   logic [REG_IDX_W-1:0] id_rd;
   logic                 id_uses_rs1;
   logic                 id_uses_rs2;
   logic                 id_reg_write;
   logic                 id_branch;
   logic                 br_resolve;
   logic                 br_taken;
   logic                 id_ready;
   logic                 issue;
   logic                 flush;
   logic [NUM_REGS-1:0]  busy_mask;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_reg_write, id_branch, br_resolve, br_taken,
      input  id_ready, issue, flush, busy_mask, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_reg_write, id_branch, br_resolve, br_taken,
      output id_ready, issue, flush, busy_mask, stall_cnt
   );

endinterface

// File: rtl/id_hazard_scheduler_inflight_pipe.sv
// Shift register of destination registers in flight from ID issue to writeback, plus busy decode.
// Latency: entry pushed at the issue edge, retires WB_LATENCY edges later; busy_mask is combinational.
// Backpressure: none; shifts every cycle, a non-push cycle inserts an invalid entry.
// Ports: clock, reset (async, active-high); push_vld/push_rd new entry; busy_mask pending-write map.
module id_hazard_scheduler_inflight_pipe
   import id_hazard_scheduler_pkg::*;
#(
   parameter int WB_LATENCY = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push_vld,
   input  logic [REG_IDX_W-1:0] push_rd,
   output logic [NUM_REGS-1:0]  busy_mask
);

   inflight_t stage_q [WB_LATENCY];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WB_LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0].vld <= push_vld;
         stage_q[0].rd  <= push_vld ? push_rd : '0;
         for (int i = 1; i < WB_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   // The last stage is still visible during the cycle whose closing edge writes
   // the register file, so a same-cycle read of that register stalls (no bypass).
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < WB_LATENCY; i++) begin
         if (stage_q[i].vld) begin
            busy_mask = busy_mask | reg_onehot(stage_q[i].rd);
         end
      end
      busy_mask[0] = 1'b0;
   end

endmodule

// File: rtl/id_hazard_scheduler.sv
// ID-stage issue scheduler: RAW stall on in-flight writes, hold while a branch is unresolved, flush on taken.
// Latency: id_ready/issue combinational; flush registered, one cycle after the taken resolve.
// Backpressure: deasserts id_ready on hazard, in BWAIT and in FLUSH; ID holds its instruction.
// Ports: clock, reset (async, active-high); bus = id_hazard_scheduler_if slave side
//        (CNT_W of the interface instance must equal CNT_W here).
module id_hazard_scheduler
   import id_hazard_scheduler_pkg::*;
#(
   parameter int WB_LATENCY = 3,
   parameter int CNT_W      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   id_hazard_scheduler_if.slave bus
);

   sched_state_e        state_q;
   sched_state_e        state_d;
   logic                flush_q;
   logic                hazard;
   logic                id_ready;
   logic                issue;
   logic                push_vld;
   logic [NUM_REGS-1:0] busy_mask;
   logic [CNT_W-1:0]    stall_cnt_q;

   // Writes to x0 are never tracked: x0 reads are always safe.
   assign push_vld = issue & bus.id_reg_write & (bus.id_rd != '0);

   id_hazard_scheduler_inflight_pipe #(
      .WB_LATENCY (WB_LATENCY)
   ) u_inflight_pipe (
      .clock     (clock),
      .reset     (reset),
      .push_vld  (push_vld),
      .push_rd   (bus.id_rd),
      .busy_mask (busy_mask)
   );

   assign hazard = (bus.id_uses_rs1 & (bus.id_rs1 != '0) & busy_mask[bus.id_rs1]) |
                   (bus.id_uses_rs2 & (bus.id_rs2 != '0) & busy_mask[bus.id_rs2]);

   assign issue = bus.id_valid & id_ready;

   always_comb begin
      state_d  = state_q;
      id_ready = 1'b0;
      unique case (state_q)
         RUN: begin
            id_ready = ~hazard;
            if (issue && bus.id_branch) begin
               state_d = BWAIT;
            end
         end
         BWAIT: begin
            if (bus.br_resolve) begin
               state_d = bus.br_taken ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= (state_d == FLUSH);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (bus.id_valid && !id_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign bus.id_ready  = id_ready;
   assign bus.issue     = issue;
   assign bus.flush     = flush_q;
   assign bus.busy_mask = busy_mask;
   assign bus.stall_cnt = stall_cnt_q;

endmodule
